// File: rtl/fpga_rx_arbiter.sv
// Round-robin arbiter that drains fpga_receiver channels onto one valid/ready
// output stream and returns a per-channel "processed" handshake.
module fpga_rx_arbiter #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS*WIDTH-1:0]     rx_data,
    input  logic [CHANNELS-1:0]           rx_received,
    output logic [CHANNELS-1:0]           rx_processed,
    input  logic [CHANNELS-1:0]           chan_enable,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(CHANNELS)-1:0]   out_channel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [15:0]                   xfer_count
);
    localparam int CW = $clog2(CHANNELS);

    typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

    state_t                state_q;
    logic [CW-1:0]         last_grant_q;
    logic [CW-1:0]         out_channel_q;
    logic [WIDTH-1:0]      out_data_q;
    logic                  out_valid_q;
    logic [CHANNELS-1:0]   rx_processed_q;
    logic [15:0]           xfer_count_q;

    logic [CHANNELS-1:0]   eligible;
    logic                  grant_found;
    logic [CW-1:0]         grant_d;
    logic [CW-1:0]         rr_idx;
    logic [WIDTH-1:0]      chan_data [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slice
        assign chan_data[i] = rx_data[i*WIDTH +: WIDTH];
    end

    assign eligible = rx_received & chan_enable;

    // Search upward from the channel after the last grant, wrapping modulo CHANNELS.
    always_comb begin
        grant_found = 1'b0;
        grant_d     = last_grant_q;
        rr_idx      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            rr_idx = CW'((int'(last_grant_q) + k) % CHANNELS);
            if (!grant_found && eligible[rr_idx]) begin
                grant_found = 1'b1;
                grant_d     = rr_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            out_valid_q    <= 1'b0;
            rx_processed_q <= '0;
            out_data_q     <= '0;
            out_channel_q  <= '0;
            xfer_count_q   <= '0;
            last_grant_q   <= CW'(CHANNELS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        out_data_q    <= chan_data[grant_d];
                        out_channel_q <= grant_d;
                        out_valid_q   <= 1'b1;
                        state_q       <= OFFER;
                    end
                end
                OFFER: begin
                    if (out_ready) begin
                        out_valid_q    <= 1'b0;
                        rx_processed_q <= CHANNELS'(1) << out_channel_q;
                        xfer_count_q   <= xfer_count_q + 16'd1;
                        state_q        <= ACK;
                    end
                end
                ACK: begin
                    // Hold "processed" until the receiver acknowledges by dropping "received".
                    if (!rx_received[out_channel_q]) begin
                        rx_processed_q <= '0;
                        last_grant_q   <= out_channel_q;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_processed = rx_processed_q;
    assign out_data     = out_data_q;
    assign out_channel  = out_channel_q;
    assign out_valid    = out_valid_q;
    assign busy         = (state_q != IDLE);
    assign xfer_count   = xfer_count_q;

endmodule

// File: doc/fpga_rx_arbiter.md
FPGA_RX_ARBITER -- requirements
Module: fpga_rx_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4, is the number of fpga_receiver channels served; the legal range is 2..8.
REQ-002 Parameter WIDTH, default 8, is the data width per channel.
REQ-003 Port clock, input, 1 bit: the system clock; all logic is rising-edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high system reset.
REQ-005 Port rx_data, input, CHANNELS*WIDTH bits: receiver data_out buses; channel i occupies [i*WIDTH +: WIDTH].
REQ-006 Port rx_received, input, CHANNELS bits: receiver "received" levels; bit i is high while channel i holds unconsumed data.
REQ-007 Port rx_processed, output, CHANNELS bits: per-receiver "processed" levels; at most one bit is high at any time.
REQ-008 Port chan_enable, input, CHANNELS bits: when a bit is low, that channel is excluded from new grants.
REQ-009 Port out_data, output, WIDTH bits: the registered byte from the granted channel.
REQ-010 Port out_channel, output, clog2(CHANNELS) bits: the index of the granted channel.
REQ-011 Port out_valid, output, 1 bit: out_data and out_channel are valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the word.
REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 Port xfer_count, output, 16 bits: the count of completed transfers.

Function
REQ-015 The FSM SHALL have three states: IDLE, OFFER, ACK.
REQ-016 Eligible set = rx_received & chan_enable, sampled in IDLE only.
REQ-017 In IDLE with a non-empty eligible set, the arbiter SHALL grant the eligible channel found first when searching upward from last_grant+1 with modulo-CHANNELS wrap-around (round-robin).
REQ-018 On a grant, the arbiter SHALL register out_data from the granted channel's rx_data and set out_channel; out_valid SHALL rise on the next cycle, and the state SHALL become OFFER.
REQ-019 In OFFER, out_valid, out_data and out_channel SHALL be held stable until out_ready is high.
REQ-020 In OFFER with out_ready high, on the next edge: out_valid becomes 0, rx_processed[granted] becomes 1, xfer_count increments (wraps from 0xFFFF to 0), and the state becomes ACK.
REQ-021 In ACK, rx_processed[granted] SHALL stay high until rx_received[granted] is sampled low; on the next edge it falls, last_grant is set to the granted index, and the state returns to IDLE.
REQ-022 Minimum cycle per transfer: grant to out_valid = 1 cycle; ready to processed = 1 cycle; received-low to IDLE = 1 cycle; IDLE grants again in the same cycle it is entered.
REQ-023 A chan_enable or rx_received change on the granted channel during OFFER SHALL NOT abort or alter the transfer.
REQ-024 A chan_enable change on other channels SHALL affect only subsequent grants.
REQ-025 If rx_received[granted] is already low on ACK entry, ACK SHALL last exactly one cycle, with rx_processed pulsed high for one cycle.
REQ-026 With the eligible set empty, the FSM SHALL stay in IDLE with out_valid=0 and rx_processed=0.
REQ-027 In IDLE, out_data and out_channel SHALL retain their last values.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set state=IDLE, out_valid=0, rx_processed=0, out_data=0, out_channel=0, xfer_count=0, busy=0, and last_grant=CHANNELS-1, so that channel 0 has first priority.
REQ-029 Reset asserted in OFFER or ACK SHALL abandon the transfer with no xfer_count increment, and rx_processed SHALL drop on that edge.

Verification
REQ-030 Single channel: rx_received=0001, rx_data[7:0]=0xA5, out_ready=1 -> out_valid=1, out_data=0xA5, out_channel=0 one cycle after the grant; rx_processed=0001 the next cycle; received dropped -> IDLE, xfer_count=1.
REQ-031 Round-robin: all four rx_received held high, data 0x10/0x21/0x32/0x43, receivers re-asserting -> grant order is 0,1,2,3,0, and each processed pulse goes only to the granted channel.
REQ-032 Backpressure: out_ready=0 for 5 cycles in OFFER -> out_valid and out_data stable for 5 cycles, rx_processed stays 0, and there is no increment until ready rises.
REQ-033 Masking: chan_enable=1101, rx_received=0010 -> no grant for 20 cycles; channel 1 enabled -> grant to channel 1.
REQ-034 Reset mid-ACK: reset pulsed during ACK of channel 2 -> all outputs 0 next edge, xfer_count unchanged at its pre-transfer value of 0, and the next grant goes to channel 0.
REQ-035 Counter wrap: xfer_count preloaded by 65535 transfers plus one more -> xfer_count=0x0000.
